// File: rtl/motor_pkg.sv
// Shared constants and state encodings for the motor command sequencer.
//   FRAME_HDR        : first byte of every command frame
//   CMD_*            : command byte codes
//   p_state_t        : frame parser states
//   r_state_t        : duty ramp states
package motor_pkg;
  localparam logic [7:0] FRAME_HDR = 8'hA5;

  localparam logic [7:0] CMD_STOP  = 8'h00;
  localparam logic [7:0] CMD_FWD   = 8'h01;
  localparam logic [7:0] CMD_REV   = 8'h02;
  localparam logic [7:0] CMD_ESTOP = 8'h03;

  typedef enum logic [2:0] {P_HDR, P_CMD, P_HI, P_LO, P_CHK} p_state_t;
  typedef enum logic       {R_RUN, R_DEAD}                   r_state_t;
endpackage

// File: rtl/motor_frame_parser.sv
// Byte-stream frame parser: A5, CMD, HI, LO, CHK with CHK = CMD^HI^LO.
//   clk, rst    : clock, async active-high reset
//   rx_data     : received byte, sampled on the rising edge of rx_done
//   rx_done     : RX done level
//   cmd_valid   : 1-cycle pulse, cycle after an accepted CHK byte
//   cmd, arg    : command code and 11-bit argument (saturated to PWM_PERIOD),
//                 valid while cmd_valid is high
//   frame_err   : 1-cycle pulse on bad checksum, unknown command or byte timeout
module motor_frame_parser
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD   = 1600,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic [10:0] arg,
  output logic        frame_err
);
  p_state_t    st, st_nxt;
  logic        rx_prev, strobe;
  logic [7:0]  cmd_r, chk_r, lo_r;
  logic [2:0]  hi_r;
  logic [31:0] tmo_cnt;
  logic        tmo_hit, ok_nxt, err_nxt;
  logic [10:0] raw_arg;

  // One strobe per byte no matter how long rx_done stays high.
  assign strobe  = rx_done & ~rx_prev;
  assign tmo_hit = (tmo_cnt == 32'(BYTE_TIMEOUT - 1));

  assign raw_arg = {hi_r, lo_r};
  assign arg     = (raw_arg > 11'(PWM_PERIOD)) ? 11'(PWM_PERIOD) : raw_arg;
  assign cmd     = cmd_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= P_HDR;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt  = st;
    ok_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (strobe) begin
      case (st)
        P_HDR: if (rx_data == FRAME_HDR) st_nxt = P_CMD;
        P_CMD: st_nxt = P_HI;
        P_HI:  st_nxt = P_LO;
        P_LO:  st_nxt = P_CHK;
        P_CHK: begin
          st_nxt = P_HDR;
          // chk_r already holds CMD^HI^LO
          if (rx_data == chk_r && cmd_r <= CMD_ESTOP) ok_nxt  = 1'b1;
          else                                        err_nxt = 1'b1;
        end
        default: st_nxt = P_HDR;
      endcase
    end else if (st != P_HDR && tmo_hit) begin
      st_nxt  = P_HDR;
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev   <= 1'b0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_r     <= '0;
      chk_r     <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      tmo_cnt   <= '0;
    end else begin
      rx_prev   <= rx_done;
      cmd_valid <= ok_nxt;
      frame_err <= err_nxt;
      if (strobe || st == P_HDR) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 32'd1;
      if (strobe) begin
        case (st)
          P_CMD: begin cmd_r <= rx_data; chk_r <= rx_data; end
          P_HI:  begin hi_r <= rx_data[2:0]; chk_r <= chk_r ^ rx_data; end
          P_LO:  begin lo_r <= rx_data; chk_r <= chk_r ^ rx_data; end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/motor_cmd_sequencer.sv
// Frame-driven duty/direction sequencer with rate-limited ramping and a
// dead time before every direction flip.
//   clk, rst    : clock, async active-high reset
//   rx_data     : received UART byte
//   rx_done     : RX done level (rising edge = new byte)
//   duty_cycle  : applied duty, 0..PWM_PERIOD
//   fwd         : 1 = forward, 0 = reverse
//   busy        : duty still moving toward its target, or in dead time
//   frame_ok    : 1-cycle pulse per accepted frame
//   frame_err   : 1-cycle pulse per rejected frame / byte timeout
//   wdog_trip   : sticky watchdog flag
// Build option: define MOTOR_WDOG_EN to enable the command watchdog;
// without it wdog_trip is tied low and the last command holds forever.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD   = 1600,
  parameter int RAMP_DIV     = 16000,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_CYCLES  = 1000,
  parameter int BYTE_TIMEOUT = 100000,
  parameter int WDOG_CYCLES  = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [10:0] duty_cycle,
  output logic        fwd,
  output logic        busy,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        wdog_trip
);
  localparam logic signed [11:0] STEP_S = 12'(RAMP_STEP);

  logic        cmd_valid, estop, tick, dead_done, wdog_hit;
  logic [7:0]  cmd;
  logic [10:0] arg, target, eff, duty_nxt;
  logic        tgt_dir;
  logic [31:0] div_cnt, dead_cnt;
  logic signed [11:0] diff, step;
  r_state_t    st, st_nxt;

  motor_frame_parser #(
    .PWM_PERIOD  (PWM_PERIOD),
    .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) u_parser (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .arg      (arg),
    .frame_err(frame_err)
  );

  assign frame_ok  = cmd_valid;
  assign estop     = cmd_valid && (cmd == CMD_ESTOP);
  assign tick      = (div_cnt == 32'(RAMP_DIV - 1));
  assign dead_done = (dead_cnt == 32'(DEAD_CYCLES - 1));
  // A pending direction change drives the ramp toward zero first.
  assign eff       = (tgt_dir == fwd) ? target : 11'd0;
  assign busy      = (st == R_DEAD) || (duty_cycle != eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= R_RUN;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    diff   = $signed({1'b0, eff}) - $signed({1'b0, duty_cycle});
    if (diff > STEP_S)       step = STEP_S;
    else if (diff < -STEP_S) step = -STEP_S;
    else                     step = diff;
    // Result stays within 0..PWM_PERIOD since step never overshoots eff.
    duty_nxt = duty_cycle + step[10:0];
    case (st)
      R_RUN:  if (tgt_dir != fwd && duty_cycle == 11'd0) st_nxt = R_DEAD;
      R_DEAD: if (dead_done) st_nxt = R_RUN;
      default: st_nxt = R_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_cycle <= '0;
      fwd        <= 1'b1;
      target     <= '0;
      tgt_dir    <= 1'b1;
      div_cnt    <= '0;
      dead_cnt   <= '0;
    end else begin
      div_cnt <= (estop || tick) ? 32'd0 : div_cnt + 32'd1;

      if (st == R_RUN && st_nxt == R_DEAD) dead_cnt <= '0;
      else if (st == R_DEAD)               dead_cnt <= dead_cnt + 32'd1;

      // Dead time was entered only because tgt_dir differed from fwd, so
      // flip unconditionally; a reverted request just ramps back afterwards.
      if (st == R_DEAD && dead_done) fwd <= ~fwd;

      if (estop)                  duty_cycle <= '0;
      else if (st == R_RUN && tick) duty_cycle <= duty_nxt;

      if (cmd_valid) begin
        case (cmd)
          CMD_STOP, CMD_ESTOP: target <= '0;
          CMD_FWD: begin tgt_dir <= 1'b1; target <= arg; end
          CMD_REV: begin tgt_dir <= 1'b0; target <= arg; end
          default: ;
        endcase
      end else if (wdog_hit) begin
        target <= '0;
      end
    end
  end

`ifdef MOTOR_WDOG_EN
  logic [31:0] wdog_cnt;
  assign wdog_hit = !wdog_trip && (wdog_cnt == 32'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (cmd_valid) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (wdog_hit) begin
      wdog_trip <= 1'b1;
    end else if (!wdog_trip) begin
      wdog_cnt  <= wdog_cnt + 32'd1;
    end
  end
`else
  assign wdog_hit  = 1'b0;
  assign wdog_trip = 1'b0;
`endif
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
module tb_motor_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [10:0] duty_cycle;
  logic        fwd, busy, frame_ok, frame_err, wdog_trip;

  int vectors = 0, miscompares = 0;
  int step_viol = 0, over_viol = 0;
  int n;
  bit exp_q[$];   // 1 = frame_ok expected, 0 = frame_err expected
  bit exp_e;
  logic [10:0] duty_prev = '0;

  always #5 clk = ~clk;

  motor_cmd_sequencer #(
    .PWM_PERIOD(1600), .RAMP_DIV(4), .RAMP_STEP(8), .DEAD_CYCLES(10),
    .BYTE_TIMEOUT(50), .WDOG_CYCLES(2000)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .duty_cycle(duty_cycle), .fwd(fwd), .busy(busy),
    .frame_ok(frame_ok), .frame_err(frame_err), .wdog_trip(wdog_trip)
  );

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Frame-event monitor: pops the scoreboard whenever the DUT reports a frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok || frame_err) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame_evt: got ok=%0d err=%0d, expected no event", frame_ok, frame_err);
        end else begin
          exp_e = exp_q.pop_front();
          if (frame_ok !== exp_e || frame_err !== !exp_e) begin
            miscompares++;
            $display("FAIL frame_evt: got ok=%0d err=%0d, expected ok=%0d", frame_ok, frame_err, exp_e);
          end
        end
      end
      if (duty_cycle > 11'd1600) over_viol++;
      if (int'(duty_cycle) > int'(duty_prev) + 8 ||
          (int'(duty_prev) > int'(duty_cycle) + 8 && duty_cycle != 11'd0)) step_viol++;
    end
    duty_prev = duty_cycle;
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_done = 1'b0;
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [39:0] fr, input int hold0);
    send_byte(fr[39:32], hold0);
    send_byte(fr[31:24], 2);
    send_byte(fr[23:16], 2);
    send_byte(fr[15:8],  2);
    send_byte(fr[7:0],   2);
  endtask

  task automatic wait_duty(input string nm, input int v, input int bound);
    int k = 0;
    while (int'(duty_cycle) != v && k < bound) begin @(negedge clk); k++; end
    check(nm, int'(duty_cycle), v);
  endtask

  task automatic measure_step(input string nm, input int exp_cycles, input int exp_delta);
    logic [10:0] d0, d1;
    int k;
    d0 = duty_cycle; k = 0;
    while (duty_cycle === d0 && k < 100) begin @(negedge clk); k++; end
    d1 = duty_cycle; k = 0;
    while (duty_cycle === d1 && k < 100) begin @(negedge clk); k++; end
    check({nm, "_period"}, k, exp_cycles);
    check({nm, "_delta"}, int'(duty_cycle) - int'(d1), exp_delta);
  endtask

  task automatic expect_drained(input string nm);
    repeat (3) @(negedge clk);
    check(nm, exp_q.size(), 0);
  endtask

  initial begin : watchdog_guard
    #1_000_000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_duty", duty_cycle, 0);
    check("rst_fwd", fwd, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_wdog", wdog_trip, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Forward 800, rate check
    exp_q.push_back(1);
    send_frame(40'hA5_01_03_20_22, 2);
    check("fwd_dir", fwd, 1);
    measure_step("ramp_up", 4, 8);
    wait_duty("ramp_to_800", 800, 2000);
    @(negedge clk);
    check("busy_low_800", busy, 0);
    repeat (10) @(negedge clk);
    check("hold_800", duty_cycle, 800);

    // Reverse 400: ramp down, dead time, flip, ramp up
    exp_q.push_back(1);
    send_frame(40'hA5_02_01_90_93, 2);
    wait_duty("rev_down_0", 0, 1000);
    check("fwd_before_dead", fwd, 1);
    @(negedge clk); @(negedge clk);
    check("busy_in_dead", busy, 1);
    n = 2;
    while (fwd !== 1'b0 && n < 100) begin
      @(negedge clk); n++;
      if (fwd === 1'b1 && duty_cycle != 11'd0) check("dead_duty_zero", duty_cycle, 0);
    end
    check("dead_len_10_12", int'(n >= 10 && n <= 12), 1);
    wait_duty("rev_up_400", 400, 1000);
    check("rev_dir", fwd, 0);
    @(negedge clk);
    check("busy_low_400", busy, 0);

    // Saturating forward target
    exp_q.push_back(1);
    send_frame(40'hA5_01_07_FF_F9, 2);
    wait_duty("sat_1600", 1600, 3000);
    check("sat_dir", fwd, 1);
    repeat (20) @(negedge clk);
    check("sat_hold", duty_cycle, 1600);
    check("sat_busy", busy, 0);

    // Bad checksum, then byte timeout
    exp_q.push_back(0);
    send_frame(40'hA5_01_03_20_23, 2);
    expect_drained("badchk_err");
    check("badchk_duty", duty_cycle, 1600);
    exp_q.push_back(0);
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    repeat (60) @(negedge clk);
    check("timeout_err", exp_q.size(), 0);
    check("timeout_duty", duty_cycle, 1600);

    // ESTOP from 800 with a long rx_done high on the header
    exp_q.push_back(1);
    send_frame(40'hA5_01_03_20_22, 2);
    wait_duty("back_to_800", 800, 1000);
    exp_q.push_back(1);
    fork
      send_frame(40'hA5_03_00_00_03, 20);
      begin
        int k = 0;
        while (frame_ok !== 1'b1 && k < 500) begin @(negedge clk); k++; end
        check("estop_seen", frame_ok, 1);
        @(negedge clk);
        check("estop_duty_next", duty_cycle, 0);
      end
    join
    check("estop_fwd", fwd, 1);
    repeat (20) @(negedge clk);
    check("estop_hold", duty_cycle, 0);
    check("estop_busy", busy, 0);

    // STOP ramps rather than jumps
    exp_q.push_back(1);
    send_frame(40'hA5_01_00_40_41, 2);
    wait_duty("small_64", 64, 500);
    exp_q.push_back(1);
    send_frame(40'hA5_00_00_00_00, 2);
    measure_step("ramp_stop", 4, -8);
    wait_duty("stop_0", 0, 500);

    // Unknown command
    exp_q.push_back(0);
    send_frame(40'hA5_07_00_00_07, 2);
    expect_drained("unk_cmd_err");
    check("unk_cmd_duty", duty_cycle, 0);

`ifdef MOTOR_WDOG_EN
    exp_q.push_back(1);
    send_frame(40'hA5_01_00_40_41, 2);
    wait_duty("wd_64", 64, 500);
    n = 0;
    while (wdog_trip !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("wdog_trip", wdog_trip, 1);
    wait_duty("wdog_ramp_0", 0, 500);
    check("wdog_sticky", wdog_trip, 1);
    exp_q.push_back(1);
    send_frame(40'hA5_01_00_40_41, 2);
    @(negedge clk);
    check("wdog_clear", wdog_trip, 0);
`endif

    expect_drained("queue_drained");
    check("never_over_1600", over_viol, 0);
    check("step_limit", step_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
